// File: rtl/fp_vec_pkg.sv
// Shared FP16 vector types and sequencer state encoding
// for the mat3*vec3 path around the dot-product unit.
package fp_vec_pkg;

    typedef logic [15:0] fp16_t;

    typedef struct packed {
        fp16_t e1;
        fp16_t e2;
        fp16_t e3;
    } vec3_t;

    typedef struct packed {
        vec3_t r0;
        vec3_t r1;
        vec3_t r2;
    } mat3_t;

    localparam fp16_t FP16_QNAN = 16'h7E00;
    localparam fp16_t FP16_ONE  = 16'h3C00;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP,
        DONE
    } seq_state_t;

    function automatic vec3_t mat_row(
        input mat3_t      m,
        input logic [1:0] r
    );
        vec3_t v;
        v = m.r2;
        case (r)
            2'd0:    v = m.r0;
            2'd1:    v = m.r1;
            default: v = m.r2;
        endcase
        return v;
    endfunction

    function automatic vec3_t set_slot(
        input vec3_t      v,
        input logic [1:0] r,
        input fp16_t      p
    );
        vec3_t o;
        o = v;
        case (r)
            2'd0:    o.e1 = p;
            2'd1:    o.e2 = p;
            default: o.e3 = p;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mat3_vec_seq.sv
// Issues one dot-product job per matrix row on a shared
// dot-product unit and gathers the three scalars.
module mat3_vec_seq
    import fp_vec_pkg::*;
#(
    parameter int TIMEOUT   = 64,
    parameter int ISSUE_GAP = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [143:0] mat,
    input  logic [47:0]  vec,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [47:0]  result,
    output logic         dp_en,
    output logic [47:0]  dp_vec_a,
    output logic [47:0]  dp_vec_b,
    input  logic [15:0]  dp_product,
    input  logic         dp_valid
);

    localparam int TMAX = (TIMEOUT > ISSUE_GAP) ? TIMEOUT : ISSUE_GAP;
    localparam int TW   = $clog2(TMAX);

    if (TIMEOUT <= 25 || ISSUE_GAP < 1) begin : g_bad_param
        $error("mat3_vec_seq: TIMEOUT must exceed 25, ISSUE_GAP >= 1");
    end

    seq_state_t    state;
    logic [1:0]    row;
    logic [TW-1:0] timer;
    mat3_t         mat_q;
    vec3_t         vec_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            row      <= 2'd0;
            timer    <= '0;
            mat_q    <= '0;
            vec_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            dp_en    <= 1'b0;
            result   <= '0;
            dp_vec_a <= '0;
            dp_vec_b <= '0;
        end else begin
            done  <= 1'b0;
            dp_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        // Operands go out straight from the ports so
                        // ISSUE sees them with dp_en in the same cycle.
                        mat_q    <= mat3_t'(mat);
                        vec_q    <= vec3_t'(vec);
                        result   <= {3{FP16_QNAN}};
                        error    <= 1'b0;
                        row      <= 2'd0;
                        timer    <= '0;
                        busy     <= 1'b1;
                        dp_en    <= 1'b1;
                        dp_vec_a <= mat_row(mat3_t'(mat), 2'd0);
                        dp_vec_b <= vec;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (dp_valid) begin
                        result <= set_slot(vec3_t'(result), row, dp_product);
                        timer  <= '0;
                        if (row == 2'd2) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            row   <= row + 2'd1;
                            state <= GAP;
                        end
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                GAP: begin
                    if (timer == TW'(ISSUE_GAP - 1)) begin
                        timer    <= '0;
                        dp_en    <= 1'b1;
                        dp_vec_a <= mat_row(mat_q, row);
                        dp_vec_b <= vec_q;
                        state    <= ISSUE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mat3_vec_seq.sv
// Scoreboard bench for mat3_vec_seq with a latency-programmable
// dot-product responder.
module tb_mat3_vec_seq;
    import fp_vec_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [143:0] mat;
    logic [47:0]  vec;
    logic         busy;
    logic         done;
    logic         error;
    logic [47:0]  result;
    logic         dp_en;
    logic [47:0]  dp_vec_a;
    logic [47:0]  dp_vec_b;
    logic [15:0]  dp_product;
    logic         dp_valid;

    mat3_vec_seq #(.TIMEOUT(64), .ISSUE_GAP(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mat       (mat),
        .vec       (vec),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .result    (result),
        .dp_en     (dp_en),
        .dp_vec_a  (dp_vec_a),
        .dp_vec_b  (dp_vec_b),
        .dp_product(dp_product),
        .dp_valid  (dp_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] a;
        logic [47:0] b;
    } op_t;

    typedef struct {
        logic [47:0] res;
        logic        err;
        int          lat;
    } res_t;

    op_t         exp_ops[$];
    res_t        exp_res[$];
    op_t         mo;
    res_t        mr;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          lat_tab[3];
    logic [15:0] prod_tab[3];
    int          en_idx = 0;
    int          stray_cyc[2] = '{-1, -1};
    int          dp_en_total = 0;
    int          dp_en_exp = 0;
    int          rsp_cnt = 0;
    bit          rsp_pend = 0;
    logic [15:0] rsp_val = '0;
    int          n, nb;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [47:0] act,
                       input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Dot-product responder: answers dp_en after lat_tab cycles
    initial begin
        dp_valid   = 1'b0;
        dp_product = '0;
        forever begin
            @(negedge clk);
            dp_valid = 1'b0;
            if (rsp_pend) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    dp_valid   = 1'b1;
                    dp_product = rsp_val;
                    rsp_pend   = 0;
                end
            end
            if (cyc == stray_cyc[0] || cyc == stray_cyc[1]) begin
                dp_valid   = 1'b1;
                dp_product = 16'hDEAD;
            end
            if (dp_en && en_idx < 3) begin
                if (lat_tab[en_idx] > 0) begin
                    rsp_pend = 1;
                    rsp_cnt  = lat_tab[en_idx];
                    rsp_val  = prod_tab[en_idx];
                end
                en_idx++;
            end
        end
    end

    // Monitor: pops expected operands and results as the DUT shows them
    initial begin
        forever begin
            @(negedge clk);
            if (dp_en) begin
                dp_en_total++;
                if (exp_ops.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dp_en unexpected: got vec_a %h want none",
                             dp_vec_a);
                end else begin
                    mo = exp_ops.pop_front();
                    chk("dp_vec_a", dp_vec_a, mo.a);
                    chk("dp_vec_b", dp_vec_b, mo.b);
                end
            end
            if (done) begin
                if (exp_res.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done unexpected: got result %h want none",
                             result);
                end else begin
                    mr = exp_res.pop_front();
                    chk("result", result, mr.res);
                    chk("error", 48'(error), 48'(mr.err));
                    chk("latency", 48'(cyc - start_cyc), 48'(mr.lat));
                end
            end
        end
    end

    task automatic start_job(
        input logic [143:0] m, input logic [47:0] v,
        input int l0, input int l1, input int l2,
        input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
        input int nexp, input logic [47:0] er, input logic e,
        input int elat, input bit expect_done
    );
        op_t  o;
        res_t r;
        for (int i = 0; i < nexp; i++) begin
            o.a = m[143 - 48*i -: 48];
            o.b = v;
            exp_ops.push_back(o);
        end
        if (expect_done) begin
            r.res = er;
            r.err = e;
            r.lat = elat;
            exp_res.push_back(r);
        end
        dp_en_exp += nexp;
        lat_tab  = '{l0, l1, l2};
        prod_tab = '{p0, p1, p2};
        @(negedge clk);
        en_idx    = 0;
        mat       = m;
        vec       = v;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        mat   = '1;
        vec   = '1;
    endtask

    task automatic wait_done(input int max, input bit disturb,
                             output int nc, output int nbusy);
        nc    = 1;
        nbusy = 0;
        while (nc <= max) begin
            if (busy) nbusy++;
            if (disturb && nc == 10) begin
                start = 1'b1;
                mat   = {9{16'h5555}};
                vec   = {3{16'h5555}};
            end
            if (disturb && nc == 11) start = 1'b0;
            if (done) break;
            @(negedge clk);
            nc++;
        end
        if (nc > max) begin
            checks++;
            errors++;
            $display("FAIL done timeout: got none want pulse within %0d", max);
        end
        @(negedge clk);
        chk("busy after done", 48'(busy), 48'(0));
        chk("done single pulse", 48'(done), 48'(0));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mat   = '0;
        vec   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst busy", 48'(busy), 48'(0));
        chk("rst done", 48'(done), 48'(0));
        chk("rst error", 48'(error), 48'(0));
        chk("rst dp_en", 48'(dp_en), 48'(0));
        chk("rst result", result, 48'h0);
        chk("rst dp_vec_a", dp_vec_a, 48'h0);
        chk("rst dp_vec_b", dp_vec_b, 48'h0);

        // Identity matrix
        start_job(144'h3C00_0000_0000_0000_3C00_0000_0000_0000_3C00,
                  48'h4000_4200_4400, 25, 25, 25,
                  16'h4000, 16'h4200, 16'h4400,
                  3, 48'h4000_4200_4400, 1'b0, 83, 1);
        wait_done(300, 0, n, nb);
        chk("identity busy cycles", 48'(nb), 48'(n));

        // All-ones rows against (1,2,3)
        start_job({9{16'h3C00}}, 48'h3C00_4000_4200, 25, 25, 25,
                  16'h4600, 16'h4600, 16'h4600,
                  3, 48'h4600_4600_4600, 1'b0, 83, 1);
        wait_done(300, 0, n, nb);
        chk("ones busy continuous", 48'(nb), 48'(83));

        // Row1 never answers
        start_job(144'h3C00_4000_0000_4000_4000_4000_3C00_0000_0000,
                  48'h3C00_3C00_3C00, 25, 0, 0,
                  16'h4200, 16'h0000, 16'h0000,
                  2, 48'h4200_7E00_7E00, 1'b1, 94, 1);
        wait_done(300, 0, n, nb);
        chk("error held", 48'(error), 48'(1));

        // Row0 answers one cycle past the timeout, landing in DONE
        start_job({9{16'h3C00}}, 48'h3C00_3C00_3C00, 65, 25, 25,
                  16'h4200, 16'h4200, 16'h4200,
                  1, 48'h7E00_7E00_7E00, 1'b1, 66, 1);
        wait_done(300, 0, n, nb);
        repeat (3) @(negedge clk);
        chk("late valid ignored", result, 48'h7E00_7E00_7E00);

        // Stray dp_valid in IDLE
        stray_cyc[0] = cyc + 2;
        repeat (4) @(negedge clk);
        chk("idle valid ignored", result, 48'h7E00_7E00_7E00);

        // Restart mid-job and stray dp_valid in GAP
        start_job(144'h4000_0000_0000_0000_4000_0000_0000_0000_4000,
                  48'h3C00_4000_4200, 25, 25, 25,
                  16'h4000, 16'h4400, 16'h4600,
                  3, 48'h4000_4400_4600, 1'b0, 83, 1);
        stray_cyc[1] = start_cyc + 27;
        wait_done(300, 1, n, nb);

        // Reset during WAIT of row1
        start_job(144'h3C00_0000_0000_0000_3C00_0000_0000_0000_3C00,
                  48'h4000_4200_4400, 25, 25, 25,
                  16'h4000, 16'h4200, 16'h4400,
                  2, 48'h0, 1'b0, 0, 0);
        repeat (39) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst busy", 48'(busy), 48'(0));
        chk("mid rst dp_en", 48'(dp_en), 48'(0));
        chk("mid rst result", result, 48'h0);
        chk("mid rst dp_vec_a", dp_vec_a, 48'h0);
        chk("mid rst dp_vec_b", dp_vec_b, 48'h0);
        chk("mid rst state", 48'(dut.state), 48'(IDLE));
        repeat (20) @(negedge clk);
        chk("post rst late valid", result, 48'h0);

        start_job(144'h3C00_0000_0000_0000_3C00_0000_0000_0000_3C00,
                  48'h4400_4200_4000, 25, 25, 25,
                  16'h4400, 16'h4200, 16'h4000,
                  3, 48'h4400_4200_4000, 1'b0, 83, 1);
        wait_done(300, 0, n, nb);

        // dp_valid exactly on the timeout threshold
        start_job(144'h3C00_3C00_3C00_4000_0000_0000_0000_0000_3C00,
                  48'h3C00_3C00_4000, 64, 25, 25,
                  16'h4400, 16'h4000, 16'h4000,
                  3, 48'h4400_4000_4000, 1'b0, 122, 1);
        wait_done(300, 0, n, nb);

        repeat (4) @(negedge clk);
        chk("dp_en total", 48'(dp_en_total), 48'(dp_en_exp));
        chk("ops drained", 48'(exp_ops.size()), 48'(0));
        chk("results drained", 48'(exp_res.size()), 48'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mat3_vec_seq.md
Name: mat3_vec_seq

Overview:
- Initiator-side sequencer for the FP16 3-element dot-product unit.
- Takes a 3x3 FP16 matrix and a 3-element FP16 vector and issues three dot-product jobs, one per matrix row, on the dot-product request/response interface.
- Collects the three scalar results into a packed 48-bit output vector.
- Sits between the transform/control logic and a single shared dot-product instance, so one multiplier/adder pipeline serves a full mat3*vec3.

Parameters:
- TIMEOUT, 64: maximum cycles in WAIT for dp_valid before aborting the job. Must be greater than 25.
- ISSUE_GAP, 2: idle cycles inserted after each captured result before the next dp_en pulse. Must be at least 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request a new mat*vec job; sampled only in IDLE
- mat  in  144  row0 = [143:96], row1 = [95:48], row2 = [47:0]; each row packed as {e1[47:32], e2[31:16], e3[15:0]}
- vec  in  48  {v1, v2, v3}, same element packing as a matrix row
- busy  out  1  high from the cycle after an accepted start until DONE exits
- done  out  1  one-cycle pulse when the job completes, whether or not it timed out
- error  out  1  set on timeout; held until the next accepted start
- result  out  48  {r0, r1, r2}, where rN = row N · vec; valid when done pulses and held until the next accepted start
- dp_en  out  1  one-cycle request pulse to the dot-product unit
- dp_vec_a  out  48  current matrix row
- dp_vec_b  out  48  latched vector
- dp_product  in  16  dot-product result
- dp_valid  in  1  dot-product result strobe; meaningful only in WAIT

Behaviour:
- Reset (synchronous, rst=1): state=IDLE, row=0, timer=0. busy, done, error, dp_en = 0. result, dp_vec_a, dp_vec_b = 0. Reset mid-job abandons the job with no done pulse; a late dp_valid afterwards is ignored.
- IDLE:
  - On start=1: latch mat and vec into internal registers, set result={3{16'h7E00}} (FP16 qNaN), clear error, row=0, go to ISSUE.
  - Inputs mat and vec may change freely after the accept cycle.
- ISSUE (1 cycle):
  - dp_en=1.
  - dp_vec_a = latched row[row]; dp_vec_b = latched vec. Both are registered outputs, valid in the same cycle as dp_en.
  - Clear timer, go to WAIT.
- WAIT:
  - dp_vec_a and dp_vec_b are held stable; dp_en=0; timer increments each cycle.
  - If dp_valid=1: write dp_product into the result slot for row (row0 → [47:32], row1 → [31:16], row2 → [15:0]).
    - row==2 → go to DONE.
    - Otherwise row++ and go to GAP.
  - Else if timer==TIMEOUT-1: error=1, go to DONE. The current and remaining slots stay qNaN.
  - dp_valid and timeout in the same cycle: dp_valid wins.
- GAP: wait ISSUE_GAP cycles with operands held, then go to ISSUE.
- DONE (1 cycle): done=1, then go to IDLE.
- busy=1 in ISSUE, WAIT, GAP and DONE.
- start while busy is ignored. No queuing.
- dp_valid outside WAIT is ignored.
- No arithmetic is performed in this block. FP16 words pass through bit-exact.
- Nominal latency with a 25-cycle dot product: done pulses 3*(1+25) + 2*ISSUE_GAP + 1 cycles after the start cycle, which is 83 cycles at defaults.

Decomposition:
- Shared package fp_vec_pkg:
  - typedef fp16_t (logic [15:0])
  - vec3_t (packed 48-bit)
  - mat3_t (packed 144-bit)
  - FP16_QNAN = 16'h7E00
  - FP16_ONE = 16'h3C00
  - seq_state_t enum {IDLE, ISSUE, WAIT, GAP, DONE}
- No sub-module needed. The block is one FSM plus a row counter, a timer and the result register.
- The top-level integration instantiates this block alongside the existing dot-product module.

Test Plan:
- Identity matrix (rows {3C00,0000,0000}, {0000,3C00,0000}, {0000,0000,3C00}), vec={4000,4200,4400}, dot-product unit at latency 25 → exactly 3 dp_en pulses, result=48'h4000_4200_4400, error=0, done 83 cycles after start.
- Every matrix row = {3C00,3C00,3C00}, vec={3C00,4000,4200} (1, 2, 3) → result={4600,4600,4600} (6.0 each); busy is continuous from the cycle after start until done.
- Bench model withholds dp_valid for row1 → error=1 after TIMEOUT cycles in WAIT; result[47:32]=row0 product, result[31:0]=32'h7E00_7E00; done pulses once; no third dp_en.
- start re-asserted in the middle of a job, and dp_valid pulsed in IDLE and GAP → both ignored; result unchanged; dp_en count stays 3.
- rst=1 during WAIT of row1 → the following cycle shows all outputs 0 and state IDLE. A subsequent start runs a clean job with the correct result.
- dp_valid arriving on the same cycle as the timeout threshold → the product is captured, error stays 0, and the sequence continues to the next row.
